patch_stream_scheduler: RTL and testbench

// - Controller sequencing one patchifier pass per frame: launches it, waits for DONE, then streams patch indices downstream.
// - Downstream (patch embedding) reads all_patches[patch_idx] on each valid/ready transfer.
// - Releases the patchifier via output_taken after the last patch or on abort.
// - Sits between the frame-level controller and the patchifier / embedding engine.

---
 rtl/patch_stream_scheduler_if.sv | 24 ++
 rtl/patch_stream_scheduler.sv | 166 ++++++++++++++++
 tb/tb_patch_stream_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/patch_stream_scheduler_if.sv
// Patch index stream between the scheduler (master) and the patch embedding engine (slave).
// The slave reads all_patches[patch_idx] on every cycle where patch_valid && patch_ready.
interface patch_stream_scheduler_if #(
  parameter int IDX_W = 4
) ();
  logic             patch_valid;
  logic             patch_ready;
  logic [IDX_W-1:0] patch_idx;
  logic             patch_last;

  modport master (
    output patch_valid,
    output patch_idx,
    output patch_last,
    input  patch_ready
  );

  modport slave (
    input  patch_valid,
    input  patch_idx,
    input  patch_last,
    output patch_ready
  );
endinterface

// File: rtl/patch_stream_scheduler.sv
// Sequences one patchifier pass per frame, streams the patch indices, then releases the patchifier.
// Define PATCH_SCHED_TIMEOUT_EN to add the WAIT_PF watchdog and the sticky err / ERROR state.
//
// state     | meaning
// IDLE      | waiting for start
// LAUNCH    | pf_en pulse to the patchifier
// WAIT_PF   | waiting for patchifier DONE (watchdog runs here when enabled)
// STREAM    | offering patch indices 0..TOTAL_NUM_PATCHES-1
// RELEASE   | pf_output_taken pulse; aborted frames return to IDLE from here
// FINISH    | done pulse and frame_count update
// ERROR     | watchdog expired; start relaunches and clears err
module patch_stream_scheduler #(
  parameter int TOTAL_NUM_PATCHES = 16,
  parameter int IDX_W             = 4,
  parameter int FRAME_CNT_W       = 16,
  parameter int TIMEOUT_CYCLES    = 8192
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [FRAME_CNT_W-1:0]   frame_count,
  output logic                     pf_en,
  input  logic [1:0]               pf_state,
  output logic                     pf_output_taken,
  patch_stream_scheduler_if.master patch
);

  localparam logic [1:0]       PF_DONE  = 2'b10;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_NUM_PATCHES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_PF,
    S_STREAM,
    S_RELEASE,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t state;
  logic   aborted;
  logic   xfer;

  assign xfer = patch.patch_valid && patch.patch_ready;

`ifdef PATCH_SCHED_TIMEOUT_EN
  localparam int                WAIT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      aborted           <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      frame_count       <= '0;
      pf_en             <= 1'b0;
      pf_output_taken   <= 1'b0;
      patch.patch_valid <= 1'b0;
      patch.patch_idx   <= '0;
      patch.patch_last  <= 1'b0;
`ifdef PATCH_SCHED_TIMEOUT_EN
      wait_cnt          <= '0;
      err_q             <= 1'b0;
`endif
    end else begin
      pf_en           <= 1'b0;
      pf_output_taken <= 1'b0;
      done            <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LAUNCH;
            pf_en <= 1'b1;
            busy  <= 1'b1;
          end
        end

        S_LAUNCH: begin
          state <= S_WAIT_PF;
`ifdef PATCH_SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        S_WAIT_PF: begin
          if (pf_state == PF_DONE) begin
            state             <= S_STREAM;
            patch.patch_valid <= 1'b1;
            patch.patch_idx   <= '0;
            patch.patch_last  <= (LAST_IDX == '0);
          end
`ifdef PATCH_SCHED_TIMEOUT_EN
          else if (wait_cnt == WAIT_LIMIT) begin
            state <= S_ERROR;
            err_q <= 1'b1;
            busy  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
`endif
        end

        S_STREAM: begin
          // abort takes priority; a coinciding transfer still happened on the bus
          if (abort || (xfer && patch.patch_last)) begin
            state             <= S_RELEASE;
            patch.patch_valid <= 1'b0;
            patch.patch_last  <= 1'b0;
            pf_output_taken   <= 1'b1;
            aborted           <= abort;
          end else if (xfer) begin
            patch.patch_idx  <= patch.patch_idx + IDX_W'(1);
            patch.patch_last <= ((patch.patch_idx + IDX_W'(1)) == LAST_IDX);
          end
        end

        S_RELEASE: begin
          if (aborted) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state       <= S_FINISH;
            done        <= 1'b1;
            frame_count <= frame_count + FRAME_CNT_W'(1);
          end
        end

        S_FINISH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        S_ERROR: begin
`ifdef PATCH_SCHED_TIMEOUT_EN
          if (start) begin
            state <= S_LAUNCH;
            err_q <= 1'b0;
            pf_en <= 1'b1;
            busy  <= 1'b1;
          end
`else
          state <= S_IDLE;
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_patch_stream_scheduler.sv
// Self-checking bench for patch_stream_scheduler with a behavioural patchifier and stream scoreboard.
// The watchdog scenario is only exercised when PATCH_SCHED_TIMEOUT_EN is defined.
module tb_patch_stream_scheduler;
  localparam int N     = 16;
  localparam int IDX_W = 4;
  localparam int FCW   = 16;
  localparam int TMO   = 8192;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           busy, done, err, pf_en, pf_output_taken;
  logic [FCW-1:0] frame_count;
  logic [1:0]     pf_state = 2'b00;

  patch_stream_scheduler_if #(.IDX_W(IDX_W)) ps ();

  patch_stream_scheduler #(
    .TOTAL_NUM_PATCHES(N),
    .IDX_W(IDX_W),
    .FRAME_CNT_W(FCW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .busy(busy),
    .done(done),
    .err(err),
    .frame_count(frame_count),
    .pf_en(pf_en),
    .pf_state(pf_state),
    .pf_output_taken(pf_output_taken),
    .patch(ps.master)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pf_en_cnt = 0, done_cnt = 0, taken_cnt = 0;
  int start_cyc = 0, first_valid_cyc = 0, last_xfer_cyc = 0;
  int taken_cyc = 0, done_cyc = 0, pf_en_cyc = 0, err_cyc = 0;
  bit first_seen = 1'b0;
  int got[$];
  int pf_delay = 0;
  bit pf_hold = 1'b0;
  int pf_left = 0;
  int exp_frames = 0;
  int en0 = 0, dn0 = 0, tk0 = 0;

  bit             prev_ok = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
  bit             prev_last = 1'b0, prev_abort = 1'b0, prev_err = 1'b0;
  int             prev_idx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard, stream-rule checks and a patchifier that reports DONE pf_delay cycles after pf_en.
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      pf_state <= 2'b00;
      prev_ok = 1'b0;
      prev_valid = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (start && !busy) begin
        start_cyc = cyc;
        first_seen = 1'b0;
      end
      if (ps.patch_valid && !first_seen) begin
        first_valid_cyc = cyc;
        first_seen = 1'b1;
      end
      if (ps.patch_valid) chk("last_flag", ps.patch_last, (ps.patch_idx == N - 1));
      if (prev_ok && prev_valid && !prev_abort && !(prev_ready && prev_last)) begin
        chk("valid_hold", ps.patch_valid, 1);
        chk("idx_next", ps.patch_idx, prev_ready ? prev_idx + 1 : prev_idx);
      end
      if (ps.patch_valid && ps.patch_ready) begin
        got.push_back(int'(ps.patch_idx));
        last_xfer_cyc = cyc;
      end
      if (pf_en) begin
        pf_en_cnt++;
        pf_en_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (pf_output_taken) begin
        taken_cnt++;
        taken_cyc = cyc;
      end
      if (err && !prev_err) err_cyc = cyc;

      if (pf_en) begin
        if (pf_hold) pf_state <= 2'b01;
        else if (pf_delay == 0) pf_state <= 2'b10;
        else begin
          pf_state <= 2'b01;
          pf_left = pf_delay;
        end
      end else if (pf_output_taken) begin
        pf_state <= 2'b00;
      end else if (pf_state == 2'b01 && !pf_hold) begin
        if (pf_left <= 1) pf_state <= 2'b10;
        else pf_left--;
      end

      prev_ok    = 1'b1;
      prev_valid = ps.patch_valid;
      prev_ready = ps.patch_ready;
      prev_last  = ps.patch_last;
      prev_abort = abort;
      prev_idx   = int'(ps.patch_idx);
      prev_err   = err;
    end
  end

  task automatic snap();
    en0 = pf_en_cnt;
    dn0 = done_cnt;
    tk0 = taken_cnt;
    got.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_pf_en"}, pf_en, 0);
    chk({tag, "_taken"}, pf_output_taken, 0);
    chk({tag, "_valid"}, ps.patch_valid, 0);
    chk({tag, "_idx"}, ps.patch_idx, 0);
    chk({tag, "_last"}, ps.patch_last, 0);
  endtask

  task automatic chk_seq(input string tag, input int nexp);
    int bad = 0;
    chk({tag, "_len"}, got.size(), nexp);
    foreach (got[i]) if (got[i] != i % N) bad++;
    chk({tag, "_seq"}, bad, 0);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready plus stray starts while busy
  task automatic drive_until_done(input int mode, input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      if (done_cnt >= target) break;
      case (mode)
        0:       ps.patch_ready = 1'b1;
        1:       ps.patch_ready = (k % 3 == 0);
        default: ps.patch_ready = 1'($urandom_range(0, 1));
      endcase
      start = (mode == 2) && busy && ($urandom_range(0, 3) == 0);
      k++;
    end
    start = 1'b0;
    chk("done_seen", done_cnt >= target, 1);
  endtask

  task automatic check_frame(input string tag, input int delay);
    chk_seq(tag, N);
    chk({tag, "_frame_count"}, frame_count, exp_frames);
    chk({tag, "_pf_en_pulses"}, pf_en_cnt - en0, 1);
    chk({tag, "_taken_pulses"}, taken_cnt - tk0, 1);
    chk({tag, "_done_pulses"}, done_cnt - dn0, 1);
    chk({tag, "_taken_lat"}, taken_cyc - last_xfer_cyc, 1);
    chk({tag, "_done_lat"}, done_cyc - last_xfer_cyc, 2);
    chk({tag, "_first_valid_lat"}, first_valid_cyc - start_cyc, 3 + delay);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic run_frame(input int mode, input int delay, input string tag);
    snap();
    pf_delay = delay;
    ps.patch_ready = 1'b1;
    pulse_start();
    drive_until_done(mode, dn0 + 1, delay + 400);
    exp_frames++;
    check_frame(tag, delay);
  endtask

  task automatic run_abort(input int k, input bit rdy);
    int n = 0;
    snap();
    pf_delay = $urandom_range(0, 10);
    ps.patch_ready = 1'b1;
    pulse_start();
    while (!(ps.patch_valid && ps.patch_idx == k) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_idx", ps.patch_idx, k);
    abort = 1'b1;
    ps.patch_ready = rdy;
    @(negedge clk);
    abort = 1'b0;
    ps.patch_ready = 1'b1;
    chk("abort_valid_drop", ps.patch_valid, 0);
    chk("abort_taken_now", pf_output_taken, 1);
    repeat (6) @(negedge clk);
    chk_seq("abort", k + int'(rdy));
    chk("abort_no_done", done_cnt - dn0, 0);
    chk("abort_taken_pulses", taken_cnt - tk0, 1);
    chk("abort_frame_count", frame_count, exp_frames);
    chk("abort_busy", busy, 0);
  endtask

  initial begin
    int n;
    ps.patch_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset = 1'b1;
    @(negedge clk);

    run_frame(0, 4100, "nominal");
    run_frame(1, 2, "backpressure");
    for (int i = 0; i < 3; i++) run_frame(2, $urandom_range(0, 20), "random");

    run_abort(5, 1'b1);
    run_abort($urandom_range(0, N - 1), 1'($urandom_range(0, 1)));

    // start held high through a whole frame: ignored while busy, relaunches once idle
    snap();
    pf_delay = 3;
    ps.patch_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (pf_en_cnt - en0 < 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    n = 0;
    while (done_cnt - dn0 < 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    exp_frames += 2;
    chk_seq("b2b", 2 * N);
    chk("b2b_pf_en_pulses", pf_en_cnt - en0, 2);
    chk("b2b_done_pulses", done_cnt - dn0, 2);
    chk("b2b_frame_count", frame_count, exp_frames);

    // reset in the middle of streaming
    snap();
    pf_delay = 2;
    ps.patch_ready = 1'b1;
    pulse_start();
    n = 0;
    while (!(ps.patch_valid && ps.patch_idx == 7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reach_idx", ps.patch_idx, 7);
    reset = 1'b0;
    #1;
    chk_reset("rst_mid");
    exp_frames = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    snap();
    repeat (10) @(negedge clk);
    chk("rst_idle_busy", busy, 0);
    chk("rst_idle_pf_en", pf_en_cnt - en0, 0);
    chk("rst_idle_valid", ps.patch_valid, 0);
    run_frame(2, 5, "post_reset");

`ifdef PATCH_SCHED_TIMEOUT_EN
    snap();
    pf_hold = 1'b1;
    pulse_start();
    n = 0;
    while (!err && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_lat", err_cyc - pf_en_cyc, TMO + 1);
    pf_hold = 1'b0;
    snap();
    pf_delay = 3;
    pulse_start();
    chk("tmo_err_cleared", err, 0);
    chk("tmo_relaunch_pf_en", pf_en, 1);
    drive_until_done(0, dn0 + 1, 400);
    exp_frames++;
    check_frame("tmo_recover", 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
